// File: rtl/inst_buff.sv
// Instruction line buffer: queues 64-bit ROM lines and hands them to decode one 32-bit word per cycle.
// Define INST_BUFF_BYPASS_EN to let a line arriving at an empty buffer reach decode in the same cycle.
module inst_buff #(
    parameter int DEPTH     = 4,
    parameter int LINEWIDTH = 64,
    parameter int WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          rst_addr_i,
    input  logic                 flush_i,
    input  logic [31:0]          flush_addr_i,
    input  logic [LINEWIDTH-1:0] line_i,
    input  logic                 line_valid_i,
    input  logic                 line_ready_i,
    output logic                 ld_line_o,
    output logic                 rom_flush_o,
    output logic [31:0]          rom_flush_addr_o,
    output logic [WIDTH-1:0]     inst_o,
    output logic [31:0]          inst_pc_o,
    output logic                 inst_valid_o,
    input  logic                 inst_ready_i,
    output logic                 idle_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [LINEWIDTH-1:0] lineMem_q [DEPTH];
    logic [28:0]          linePc_q  [DEPTH];

    logic [PW-1:0]        wrPtr_q, wrPtr_d;
    logic [PW-1:0]        rdPtr_q, rdPtr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 half_q, half_d;
    logic [28:0]          fetchPc_q, fetchPc_d;

    logic                 wrEn;
    logic                 fifoValid;
    logic                 bypassHit;
    logic                 pop;
    logic                 retire;
    logic [LINEWIDTH-1:0] outLine;
    logic [28:0]          outPc;
    logic                 unusedRstBits;

    assign rom_flush_o      = flush_i;
    assign rom_flush_addr_o = flush_addr_i;

    // Throttle is judged on the count at cycle start, so a pop never re-opens a full buffer early.
    assign ld_line_o = ~flush_i & (count_q < CW'(DEPTH));
    assign wrEn      = line_valid_i & ld_line_o;
    assign fifoValid = (count_q != '0);

`ifdef INST_BUFF_BYPASS_EN
    assign bypassHit = ~fifoValid & wrEn;
`else
    assign bypassHit = 1'b0;
`endif

    assign inst_valid_o = ~rst & ~flush_i & (fifoValid | bypassHit);
    assign outLine      = bypassHit ? line_i    : lineMem_q[rdPtr_q];
    assign outPc        = bypassHit ? fetchPc_q : linePc_q[rdPtr_q];
    assign inst_o       = inst_valid_o ? (half_q ? outLine[LINEWIDTH-1:WIDTH] : outLine[WIDTH-1:0]) : '0;
    assign inst_pc_o    = inst_valid_o ? {outPc, half_q, 2'b00} : '0;

    assign pop    = inst_valid_o & inst_ready_i;
    assign retire = pop & half_q;

    assign idle_o        = ~fifoValid & ~line_ready_i;
    assign unusedRstBits = ^rst_addr_i[1:0];

    always_comb begin
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        count_d   = count_q;
        half_d    = half_q;
        fetchPc_d = fetchPc_q;
        if (flush_i) begin
            wrPtr_d   = '0;
            rdPtr_d   = '0;
            count_d   = '0;
            half_d    = flush_addr_i[2];
            fetchPc_d = flush_addr_i[31:3];
        end else begin
            if (wrEn) begin
                wrPtr_d   = wrPtr_q + 1'b1;
                fetchPc_d = fetchPc_q + 29'd1;
            end
            if (pop) begin
                half_d = ~half_q;
                if (half_q) begin
                    rdPtr_d = rdPtr_q + 1'b1;
                end
            end
            case ({wrEn, retire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            half_q    <= rst_addr_i[2];
            fetchPc_q <= rst_addr_i[31:3];
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            half_q    <= half_d;
            fetchPc_q <= fetchPc_d;
        end
    end

    // Line storage carries no reset; entries are only read once count says they were written.
    always_ff @(posedge clk) begin
        if (~rst & wrEn) begin
            lineMem_q[wrPtr_q] <= line_i;
            linePc_q[wrPtr_q]  <= fetchPc_q;
        end
    end

endmodule
